// File: rtl/vr_pkg.sv
// Shared helpers for the vr_* valid/ready block family.
// Counter-width and wrapping pointer-increment functions.
package vr_pkg;

    // Width needed to hold an occupancy in 0..depth.
    function automatic int vr_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Advance a 0..depth-1 pointer, wrapping depth-1 back to 0.
    function automatic int unsigned vr_ptr_inc(
        input int unsigned ptr,
        input int unsigned depth
    );
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/vr_buf_mem.sv
// DEPTH x WIDTH flop array, one write port, one async read port.
// Ports: clk, we/waddr/wdata (write), raddr/rdata (read). No reset.
module vr_buf_mem #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/vr_elastic_buf.sv
// Valid/ready elastic buffer with DEPTH slots, occupancy and flush.
// Ports: clk, rst_n, flush, in_valid/in_ready/in_data,
//        out_valid/out_ready/out_data, count, almost_full.
module vr_elastic_buf
    import vr_pkg::*;
#(
    parameter int WIDTH        = 32,
    parameter int DEPTH        = 4,
    parameter int AFULL_THRESH = DEPTH - 1,
    localparam int CW          = vr_cnt_w(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [CW-1:0]    count,
    output logic             almost_full
);

    localparam int PW = $clog2(DEPTH);

    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr_nxt;
    logic [PW-1:0]    rd_ptr_nxt;
    logic             init_q;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] rdata;

    // in_ready depends only on flops and flush, never on out_ready.
    assign in_ready    = init_q && (count != CW'(DEPTH)) && !flush;
    assign out_valid   = (count != '0) && !flush;
    assign push        = in_valid && in_ready;
    assign pop         = out_valid && out_ready;
    assign almost_full = count >= CW'(AFULL_THRESH);

    // Gate the read so unwritten storage never reaches the output.
    assign out_data = out_valid ? rdata : '0;

    assign wr_ptr_nxt = PW'(vr_ptr_inc(32'(wr_ptr), 32'(DEPTH)));
    assign rd_ptr_nxt = PW'(vr_ptr_inc(32'(rd_ptr), 32'(DEPTH)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            init_q <= 1'b0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            init_q <= 1'b1;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr_nxt;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr_nxt;
                end
                unique case ({push, pop})
                    2'b10:   count <= count + CW'(1);
                    2'b01:   count <= count - CW'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    vr_buf_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (PW)
    ) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

endmodule

// File: tb/tb_vr_elastic_buf.sv
// Bench for vr_elastic_buf: DEPTH=4 and DEPTH=3 instances,
// each checked every cycle against a queue model.
module tb_vr_elastic_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush_s     [2];
    logic        in_valid_s  [2];
    logic        out_ready_s [2];
    logic [31:0] in_data_s   [2];
    logic        in_ready_s  [2];
    logic        out_valid_s [2];
    logic        af_s        [2];
    logic [31:0] out_data_s  [2];
    logic [2:0]  count_s     [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    task automatic chk(input string name, input int idx,
                       input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0h expected %0h",
                     name, idx, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 2; g++) begin : blk
        localparam int D  = (g == 0) ? 4 : 3;
        localparam int AF = D - 1;

        logic                       ir;
        logic                       ov;
        logic                       af;
        logic [31:0]                od;
        logic [$clog2(D+1)-1:0]     cnt;

        vr_elastic_buf #(
            .WIDTH (32),
            .DEPTH (D)
        ) dut (
            .clk         (clk),
            .rst_n       (rst_n),
            .flush       (flush_s[g]),
            .in_valid    (in_valid_s[g]),
            .in_ready    (ir),
            .in_data     (in_data_s[g]),
            .out_valid   (ov),
            .out_ready   (out_ready_s[g]),
            .out_data    (od),
            .count       (cnt),
            .almost_full (af)
        );

        assign in_ready_s[g]  = ir;
        assign out_valid_s[g] = ov;
        assign af_s[g]        = af;
        assign out_data_s[g]  = od;
        assign count_s[g]     = 3'(cnt);

        // Model: a FIFO queue plus "has a clock edge passed since reset".
        int unsigned q[$];
        bit          init = 1'b0;

        always @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q.delete();
                init = 1'b0;
            end else begin
                bit m_ir;
                bit m_ov;
                int unsigned w;
                m_ir = init && (q.size() < D) && !flush_s[g];
                m_ov = (q.size() != 0) && !flush_s[g];
                w    = in_data_s[g];
                init = 1'b1;
                if (flush_s[g]) begin
                    q.delete();
                end else begin
                    if (m_ov && out_ready_s[g]) void'(q.pop_front());
                    if (m_ir && in_valid_s[g]) q.push_back(w);
                end
            end
        end

        always @(negedge clk) begin
            if (rst_n) begin
                bit e_ir;
                bit e_ov;
                int unsigned e_od;
                e_ir = init && (q.size() < D) && !flush_s[g];
                e_ov = (q.size() != 0) && !flush_s[g];
                e_od = e_ov ? q[0] : 0;
                chk("in_ready", g, in_ready_s[g], e_ir);
                chk("out_valid", g, out_valid_s[g], e_ov);
                chk("out_data", g, out_data_s[g], e_od);
                chk("count", g, count_s[g], q.size());
                chk("almost_full", g, af_s[g], q.size() >= AF);
            end
        end
    end

    initial begin
        int exp_pop;
        for (int g = 0; g < 2; g++) begin
            flush_s[g]     = 1'b0;
            in_valid_s[g]  = 1'b0;
            out_ready_s[g] = 1'b0;
            in_data_s[g]   = '0;
        end

        // Reset state, asynchronous, before any clock edge.
        #1;
        chk("rst_count", 0, count_s[0], 0);
        chk("rst_in_ready", 0, in_ready_s[0], 0);
        chk("rst_out_valid", 0, out_valid_s[0], 0);
        chk("rst_out_data", 0, out_data_s[0], 0);
        chk("rst_afull", 0, af_s[0], 0);
        step();
        step();
        rst_n = 1'b1;
        #1;
        chk("rel_in_ready0", 0, in_ready_s[0], 0);
        step();
        chk("rel_in_ready1", 0, in_ready_s[0], 1);

        // Fill with 1,2,3,4 and out_ready low.
        in_valid_s[0] = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            in_data_s[0] = 32'(k);
            step();
            if (k == 2) chk("afull_at2", 0, af_s[0], 0);
            if (k == 3) chk("afull_at3", 0, af_s[0], 1);
        end
        in_data_s[0] = 32'd5;
        chk("full_count", 0, count_s[0], 4);
        chk("full_model", 0, blk[0].q.size(), 4);
        chk("full_in_ready", 0, in_ready_s[0], 0);
        chk("full_afull", 0, af_s[0], 1);
        chk("full_head", 0, out_data_s[0], 1);

        // Drain while pushing: strict order, one bubble from full.
        out_ready_s[0] = 1'b1;
        exp_pop = 1;
        chk("bubble", 0, in_ready_s[0], 0);
        for (int c = 0; c < 12; c++) begin
            bit hs_in;
            hs_in = in_valid_s[0] && in_ready_s[0];
            if (c >= 2) chk("steady_ready", 0, in_ready_s[0], 1);
            if (out_valid_s[0]) begin
                chk("order", 0, out_data_s[0], exp_pop);
                exp_pop++;
            end
            step();
            if (hs_in) in_data_s[0] = in_data_s[0] + 1;
        end
        in_valid_s[0] = 1'b0;
        for (int c = 0; c < 10 && out_valid_s[0]; c++) begin
            chk("order", 0, out_data_s[0], exp_pop);
            exp_pop++;
            step();
        end
        chk("drained", 0, count_s[0], 0);
        chk("pop_total", 0, exp_pop, 16);
        out_ready_s[0] = 1'b0;

        // Single push of 0xA5 into empty, then pop.
        in_valid_s[0] = 1'b1;
        in_data_s[0]  = 32'hA5;
        step();
        in_valid_s[0] = 1'b0;
        chk("a5_valid", 0, out_valid_s[0], 1);
        chk("a5_data", 0, out_data_s[0], 32'hA5);
        chk("a5_count", 0, count_s[0], 1);
        out_ready_s[0] = 1'b1;
        step();
        out_ready_s[0] = 1'b0;
        chk("a5_pop_count", 0, count_s[0], 0);
        chk("a5_pop_data", 0, out_data_s[0], 0);

        // Flush at count 2 with push and pop requested.
        in_valid_s[0] = 1'b1;
        in_data_s[0]  = 32'h11;
        step();
        in_data_s[0]  = 32'h22;
        step();
        chk("pre_flush_count", 0, count_s[0], 2);
        in_data_s[0]   = 32'h33;
        out_ready_s[0] = 1'b1;
        flush_s[0]     = 1'b1;
        #1;
        chk("flush_in_ready", 0, in_ready_s[0], 0);
        chk("flush_out_valid", 0, out_valid_s[0], 0);
        step();
        flush_s[0]     = 1'b0;
        out_ready_s[0] = 1'b0;
        chk("post_flush_count", 0, count_s[0], 0);
        chk("post_flush_valid", 0, out_valid_s[0], 0);
        in_data_s[0] = 32'h77;
        step();
        in_valid_s[0] = 1'b0;
        chk("post_flush_head", 0, out_data_s[0], 32'h77);
        out_ready_s[0] = 1'b1;
        step();
        out_ready_s[0] = 1'b0;

        // Asynchronous reset mid-stream at count 3.
        in_valid_s[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_data_s[0] = 32'h40 + 32'(k);
            step();
        end
        in_valid_s[0] = 1'b0;
        chk("pre_rst_count", 0, count_s[0], 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 0, count_s[0], 0);
        chk("arst_valid", 0, out_valid_s[0], 0);
        chk("arst_ready", 0, in_ready_s[0], 0);
        chk("arst_data", 0, out_data_s[0], 0);
        chk("arst_model", 0, blk[0].q.size(), 0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rerel_ready0", 0, in_ready_s[0], 0);
        step();
        chk("rerel_ready1", 0, in_ready_s[0], 1);

        // Random traffic on both depths, with occasional flush.
        for (int c = 0; c < 10000; c++) begin
            for (int g = 0; g < 2; g++) begin
                if (!in_valid_s[g] || in_ready_s[g] || flush_s[g]) begin
                    in_valid_s[g] = ($urandom_range(0, 3) != 0);
                    in_data_s[g]  = $urandom;
                end
                out_ready_s[g] = ($urandom_range(0, 2) != 0);
                flush_s[g]     = ($urandom_range(0, 199) == 0);
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/vr_elastic_buf.md
# vr_elastic_buf

Parametrised valid/ready elastic buffer holding up to DEPTH words. Generalises the single-entry valid/ready pipe stage with configurable depth, occupancy and almost-full reporting, synchronous flush, and a registered-only `in_ready`, so there is no combinational path from `out_ready` to `in_ready`. It sits between producer and consumer pipeline stages wherever timing closure or rate decoupling needs more than one slot of slack.

## Interface
- `WIDTH`, 32, payload width in bits (≥1).
- `DEPTH`, 4, number of storage entries (≥2; need not be a power of two).
- `AFULL_THRESH`, DEPTH-1, occupancy at or above which `almost_full` asserts (1..DEPTH).
- `CW` (localparam), $clog2(DEPTH+1), occupancy counter width.

Ports:
- `clk` in 1: single clock, all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `flush` in 1: synchronous discard of all buffered entries.
- `in_valid` in 1: upstream word valid.
- `in_ready` out 1: buffer can accept a word this cycle.
- `in_data` in WIDTH: upstream payload.
- `out_valid` out 1: head entry valid.
- `out_ready` in 1: downstream accepts the head entry.
- `out_data` out WIDTH: head payload.
- `count` out CW: current occupancy, 0..DEPTH.
- `almost_full` out 1: `count >= AFULL_THRESH`.

## Operation
- **Push.** A push occurs when `in_valid && in_ready`. It writes `in_data` at `wr_ptr` and advances `wr_ptr`.
- **Pop.** A pop occurs when `out_valid && out_ready`. It advances `rd_ptr`.
- **Pointer wrap.** Both pointers count 0..DEPTH-1, and DEPTH-1 wraps to 0.
- **Count update.** `count` goes +1 on push only, -1 on pop only, and stays unchanged on a simultaneous push and pop.
- **Flush.** While `flush` = 1, `in_ready` and `out_valid` are forced to 0, so no handshake can occur. On the next edge `count`, `wr_ptr` and `rd_ptr` return to 0. The contents of storage are don't-care.
- **Init flop.** `init_q` resets to 0 and sets to 1 on the first edge after `rst_n` deasserts.
- **`in_ready`** = `init_q && (count != DEPTH) && !flush`.
- **`out_valid`** = `(count != 0) && !flush`.
- **`out_data`** = storage[`rd_ptr`] when `out_valid` = 1; otherwise `'0`.
- **Storage** is not reset. Nothing may read storage that has not been written.
- **Handshake rules.** Upstream may not drop `in_valid` or change `in_data` before acceptance; the buffer does not check this. The buffer never drops `out_valid` or changes `out_data` without a pop, except on flush or reset.

## Timing
- **Reset values** while `rst_n` = 0: `in_ready` 0, `out_valid` 0, `out_data` 0, `count` 0, `almost_full` 0 (or 1 if AFULL_THRESH would be 0, which is illegal).
- **After reset release:** `in_ready` rises 1 cycle after `rst_n` deasserts.
- **Latency:** a word pushed at edge N is visible on `out_data` with `out_valid` = 1 from edge N (registered path, 1 cycle). There is no same-cycle bypass.
- **Throughput:** 1 word/cycle when 0 < `count` < DEPTH.
- **Full:** `in_ready` = 0 even if `out_ready` = 1. The pop frees a slot and `in_ready` rises the cycle after. This costs one bubble per full episode.
- **Empty:** `out_valid` = 0. A push makes `out_valid` = 1 the next cycle.
- **Simultaneous push and pop at `count` = 1:** `count` stays 1 and the head becomes the new word.
- **Flush with push/pop requested:** both are suppressed and `count` = 0 next cycle. A push attempted in the cycle after flush is accepted normally.
- **Reset mid-operation:** all state clears asynchronously and any in-flight words are lost. `in_ready` stays 0 for one cycle after release.
- **Status timing:** `count` and `almost_full` reflect registered state; they are combinational from flops only.

## Structure
- **Package `vr_pkg`:** `vr_cnt_w(depth)` function returning $clog2(depth+1), and a pointer-increment-with-wrap function shared with later vr_* blocks.
- **Sub-module `vr_buf_mem`:** DEPTH×WIDTH flop array with one write port (`we`, `waddr`, `wdata`) and one asynchronous read port (`raddr`, `rdata`), no reset.
- **Top level:** pointers, counter, `init_q`, flush gating and output muxing.

## Test plan
- Reset, then hold `in_valid` = 1 with data 0x1,0x2,… and `out_ready` = 0 (DEPTH = 4) -> `in_ready` rises 1 cycle after release; 4 words accepted; `count` = 4, `in_ready` = 0, `almost_full` = 1 from `count` = 3.
- From full, assert `out_ready` = 1 continuously with `in_valid` = 1 -> `out_data` 0x1,0x2,0x3,0x4,… in order, no loss or duplication; one bubble on `in_ready`, then 1 word/cycle steady state.
- Empty buffer, single push of 0xA5 -> `out_valid` = 1 with `out_data` = 0xA5 on the next cycle; `count` = 1; pop -> `count` = 0, `out_data` = 0.
- DEPTH = 3, random `in_valid`/`out_ready` for 10k cycles -> scoreboard order matches, `count` always 0..3, pointers wrap correctly past 2.
- `count` = 2, assert `flush` together with `in_valid` = 1 and `out_ready` = 1 -> no handshake that cycle, `count` = 0 next cycle, `out_valid` = 0; next pushed word is the first popped.
- Assert `rst_n` = 0 asynchronously mid-stream with `count` = 3 -> `count`, `out_valid`, `in_ready`, `out_data` go to 0 immediately without a clock edge; normal operation resumes one cycle after release.
